// File: rtl/dcache_snoop_cpu_arbiter.sv
// Sequences ACE snoops and round-robin CPU ports onto the single dcache lookup path, one transaction at a time.
// Snoops have priority, capped at MAX_SNOOP_BURST consecutive grants while any CPU port is waiting.
module dcache_snoop_cpu_arbiter #(
  parameter int NR_CPU_PORTS     = 3,
  parameter int ADDR_WIDTH       = 64,
  parameter int SNOOP_TYPE_WIDTH = 4,
  parameter int MAX_SNOOP_BURST  = 4,
  localparam int PORT_W          = (NR_CPU_PORTS > 1) ? $clog2(NR_CPU_PORTS) : 1,
  localparam int STREAK_W        = $clog2(MAX_SNOOP_BURST + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NR_CPU_PORTS-1:0]            cpu_req_i,
  input  logic [NR_CPU_PORTS-1:0]            cpu_we_i,
  input  logic [NR_CPU_PORTS*ADDR_WIDTH-1:0] cpu_addr_i,
  output logic [NR_CPU_PORTS-1:0]            cpu_gnt_o,
  input  logic                               snoop_valid_i,
  input  logic [ADDR_WIDTH-1:0]              snoop_addr_i,
  input  logic [SNOOP_TYPE_WIDTH-1:0]        snoop_type_i,
  output logic                               snoop_ready_o,
  output logic                               lookup_valid_o,
  input  logic                               lookup_ready_i,
  output logic [ADDR_WIDTH-1:0]              lookup_addr_o,
  output logic                               lookup_we_o,
  output logic                               lookup_is_snoop_o,
  output logic [SNOOP_TYPE_WIDTH-1:0]        lookup_snoop_type_o,
  output logic [PORT_W-1:0]                  lookup_port_o,
  input  logic                               done_i,
  output logic                               busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_e;

  state_e                      state_q, state_d;
  logic [PORT_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [STREAK_W-1:0]         streak_q, streak_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic                        we_q, we_d;
  logic                        snoop_q, snoop_d;
  logic [SNOOP_TYPE_WIDTH-1:0] type_q, type_d;
  logic [PORT_W-1:0]           port_q, port_d;

  logic              cpu_any;
  logic              snoop_win;
  logic              cpu_found;
  logic [PORT_W-1:0] cpu_sel;
  logic              handshake;

  // Round-robin search starting at rr_ptr, wrapping modulo NR_CPU_PORTS.
  always_comb begin
    int                idx;
    logic [PORT_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    cpu_found = 1'b0;
    cpu_sel   = '0;
    cpu_any   = |cpu_req_i;
    snoop_win = snoop_valid_i && (!cpu_any || (streak_q < STREAK_W'(MAX_SNOOP_BURST)));
    for (int i = 0; i < NR_CPU_PORTS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NR_CPU_PORTS) idx = idx - NR_CPU_PORTS;
      cand = PORT_W'(idx);
      if (!cpu_found && cpu_req_i[cand]) begin
        cpu_found = 1'b1;
        cpu_sel   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    streak_d  = streak_q;
    addr_d    = addr_q;
    we_d      = we_q;
    snoop_d   = snoop_q;
    type_d    = type_q;
    port_d    = port_q;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        if (snoop_valid_i || cpu_any) begin
          state_d = ISSUE;
          if (snoop_win) begin
            addr_d  = snoop_addr_i;
            we_d    = 1'b0;
            snoop_d = 1'b1;
            type_d  = snoop_type_i;
            port_d  = '0;
          end else begin
            addr_d  = cpu_addr_i[int'(cpu_sel)*ADDR_WIDTH +: ADDR_WIDTH];
            we_d    = cpu_we_i[cpu_sel];
            snoop_d = 1'b0;
            type_d  = '0;
            port_d  = cpu_sel;
          end
        end
      end
      ISSUE: begin
        if (lookup_ready_i) begin
          handshake = 1'b1;
          state_d   = WAIT_DONE;
          if (snoop_q) begin
            streak_d = (streak_q == STREAK_W'(MAX_SNOOP_BURST)) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
            rr_ptr_d = (port_q == PORT_W'(NR_CPU_PORTS - 1)) ? '0 : port_q + 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      streak_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      snoop_q  <= 1'b0;
      type_q   <= '0;
      port_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      snoop_q  <= snoop_d;
      type_q   <= type_d;
      port_q   <= port_d;
    end
  end

  // Grant pulses are combinational so they line up with the accepting cycle.
  always_comb begin
    cpu_gnt_o = '0;
    if (handshake && !snoop_q) cpu_gnt_o[port_q] = 1'b1;
  end

  assign snoop_ready_o       = handshake && snoop_q;
  assign lookup_valid_o      = (state_q == ISSUE);
  assign lookup_addr_o       = addr_q;
  assign lookup_we_o         = we_q;
  assign lookup_is_snoop_o   = snoop_q;
  assign lookup_snoop_type_o = type_q;
  assign lookup_port_o       = port_q;
  assign busy_o              = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_snoop_cpu_arbiter.sv
// Directed bench for dcache_snoop_cpu_arbiter: inputs driven 1ns after posedge, outputs sampled at negedge.
module tb_dcache_snoop_cpu_arbiter;
  localparam int N  = 3;
  localparam int AW = 64;
  localparam int TW = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    cpu_req_i;
  logic [N-1:0]    cpu_we_i;
  logic [N*AW-1:0] cpu_addr_i;
  logic [N-1:0]    cpu_gnt_o;
  logic            snoop_valid_i;
  logic [AW-1:0]   snoop_addr_i;
  logic [TW-1:0]   snoop_type_i;
  logic            snoop_ready_o;
  logic            lookup_valid_o;
  logic            lookup_ready_i;
  logic [AW-1:0]   lookup_addr_o;
  logic            lookup_we_o;
  logic            lookup_is_snoop_o;
  logic [TW-1:0]   lookup_snoop_type_o;
  logic [1:0]      lookup_port_o;
  logic            done_i;
  logic            busy_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  dcache_snoop_cpu_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_gnt_o(cpu_gnt_o),
    .snoop_valid_i(snoop_valid_i), .snoop_addr_i(snoop_addr_i), .snoop_type_i(snoop_type_i),
    .snoop_ready_o(snoop_ready_o),
    .lookup_valid_o(lookup_valid_o), .lookup_ready_i(lookup_ready_i), .lookup_addr_o(lookup_addr_o),
    .lookup_we_o(lookup_we_o), .lookup_is_snoop_o(lookup_is_snoop_o),
    .lookup_snoop_type_o(lookup_snoop_type_o), .lookup_port_o(lookup_port_o),
    .done_i(done_i), .busy_o(busy_o)
  );

  // done_i may only be driven while a transaction is waiting for completion.
  always @(negedge clk_i) begin
    if (rst_ni && done_i) assert (busy_o && !lookup_valid_o) else $error("done_i outside WAIT_DONE");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_req_i      = '0;
    cpu_we_i       = '0;
    cpu_addr_i     = '0;
    snoop_valid_i  = 1'b0;
    snoop_addr_i   = '0;
    snoop_type_i   = '0;
    lookup_ready_i = 1'b1;
    done_i         = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    nxt();
    nxt();
    rst_ni = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(lookup_valid_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_gnt"}, 64'(cpu_gnt_o), 64'd0);
    chk({tag, "_sready"}, 64'(snoop_ready_o), 64'd0);
    chk({tag, "_addr"}, lookup_addr_o, 64'd0);
    chk({tag, "_we"}, 64'(lookup_we_o), 64'd0);
    chk({tag, "_is_snoop"}, 64'(lookup_is_snoop_o), 64'd0);
    chk({tag, "_type"}, 64'(lookup_snoop_type_o), 64'd0);
    chk({tag, "_port"}, 64'(lookup_port_o), 64'd0);
  endtask

  // Waits (bounded) for a grant; who = port index, -1 for snoop, -2 on timeout.
  task automatic get_grant(output int who);
    who = -2;
    for (int c = 0; c < 20 && who == -2; c++) begin
      nxt();
      @(negedge clk_i);
      if (snoop_ready_o) who = -1;
      for (int k = 0; k < N; k++) if (cpu_gnt_o[k]) who = k;
    end
    if (who != -2) chk("gnt_onehot", 64'($countones(cpu_gnt_o) + int'(snoop_ready_o)), 64'd1);
  endtask

  task automatic finish_txn();
    nxt();
    nxt();
    done_i = 1'b1;
    nxt();
    done_i = 1'b0;
  endtask

  int exp_rr[5]     = '{0, 1, 2, 0, 1};
  int exp_burst[10] = '{-1, -1, -1, -1, 2, -1, -1, -1, -1, 2};
  int who;
  logic [63:0] a5;

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    #2;
    check_all_zero("rst");
    do_reset();

    // Single read from port 1.
    cpu_req_i[1] = 1'b1;
    cpu_addr_i[1*AW +: AW] = 64'h8000_1040;
    @(negedge clk_i);
    chk("t1_idle_busy", 64'(busy_o), 64'd0);
    nxt();
    @(negedge clk_i);
    chk("t1_valid", 64'(lookup_valid_o), 64'd1);
    chk("t1_addr", lookup_addr_o, 64'h8000_1040);
    chk("t1_port", 64'(lookup_port_o), 64'd1);
    chk("t1_we", 64'(lookup_we_o), 64'd0);
    chk("t1_gnt", 64'(cpu_gnt_o), 64'b010);
    chk("t1_busy", 64'(busy_o), 64'd1);
    nxt();
    cpu_req_i = '0;
    @(negedge clk_i);
    chk("t1_wait_valid", 64'(lookup_valid_o), 64'd0);
    chk("t1_wait_gnt", 64'(cpu_gnt_o), 64'd0);
    chk("t1_wait_busy", 64'(busy_o), 64'd1);
    nxt();
    done_i = 1'b1;
    @(negedge clk_i);
    chk("t1_done_busy", 64'(busy_o), 64'd1);
    nxt();
    done_i = 1'b0;
    @(negedge clk_i);
    chk("t1_idle_after", 64'(busy_o), 64'd0);

    // Snoop and port0 write together: snoop first.
    snoop_valid_i = 1'b1;
    snoop_addr_i  = 64'h100;
    snoop_type_i  = 4'b0001;
    cpu_req_i[0]  = 1'b1;
    cpu_we_i[0]   = 1'b1;
    cpu_addr_i[0 +: AW] = 64'h2000;
    get_grant(who);
    chk("t2_first", 64'(who), 64'(-1));
    chk("t2_is_snoop", 64'(lookup_is_snoop_o), 64'd1);
    chk("t2_addr", lookup_addr_o, 64'h100);
    chk("t2_type", 64'(lookup_snoop_type_o), 64'd1);
    chk("t2_we", 64'(lookup_we_o), 64'd0);
    nxt();
    snoop_valid_i = 1'b0;
    nxt();
    done_i = 1'b1;
    nxt();
    done_i = 1'b0;
    @(negedge clk_i);
    chk("t2_gap_valid", 64'(lookup_valid_o), 64'd0);
    chk("t2_gap_busy", 64'(busy_o), 64'd0);
    nxt();
    @(negedge clk_i);
    chk("t2_p0_valid", 64'(lookup_valid_o), 64'd1);
    chk("t2_p0_gnt", 64'(cpu_gnt_o), 64'b001);
    chk("t2_p0_we", 64'(lookup_we_o), 64'd1);
    chk("t2_p0_snoop", 64'(lookup_is_snoop_o), 64'd0);
    chk("t2_p0_addr", lookup_addr_o, 64'h2000);
    nxt();
    cpu_req_i = '0;
    finish_txn();

    // All ports held: round-robin with wrap.
    do_reset();
    cpu_req_i = 3'b111;
    for (int g = 0; g < 5; g++) begin
      get_grant(who);
      chk($sformatf("t3_grant%0d", g), 64'(who), 64'(exp_rr[g]));
      finish_txn();
    end
    cpu_req_i = '0;

    // Snoop burst limit against port 2.
    do_reset();
    snoop_valid_i = 1'b1;
    snoop_addr_i  = 64'h40;
    snoop_type_i  = 4'b0111;
    cpu_req_i[2]  = 1'b1;
    cpu_addr_i[2*AW +: AW] = 64'h3300;
    for (int g = 0; g < 10; g++) begin
      get_grant(who);
      chk($sformatf("t4_grant%0d", g), 64'(who), 64'(exp_burst[g]));
      finish_txn();
    end
    clear_inputs();

    // Controller stalls three cycles in ISSUE.
    do_reset();
    lookup_ready_i = 1'b0;
    cpu_req_i[0]   = 1'b1;
    a5             = 64'hDEAD_BEEF_0000_0080;
    cpu_addr_i[0 +: AW] = a5;
    for (int c = 1; c <= 4; c++) begin
      nxt();
      if (c == 4) lookup_ready_i = 1'b1;
      @(negedge clk_i);
      chk($sformatf("t5_valid_c%0d", c), 64'(lookup_valid_o), 64'd1);
      chk($sformatf("t5_addr_c%0d", c), lookup_addr_o, a5);
      chk($sformatf("t5_gnt_c%0d", c), 64'(cpu_gnt_o), (c == 4) ? 64'b001 : 64'd0);
    end
    nxt();
    cpu_req_i = '0;
    @(negedge clk_i);
    chk("t5_gnt_after", 64'(cpu_gnt_o), 64'd0);
    finish_txn();

    // Asynchronous reset in WAIT_DONE clears rr_ptr.
    do_reset();
    cpu_req_i = 3'b011;
    get_grant(who);
    chk("t6_g0", 64'(who), 64'd0);
    finish_txn();
    get_grant(who);
    chk("t6_g1", 64'(who), 64'd1);
    nxt();
    @(negedge clk_i);
    chk("t6_wait_busy", 64'(busy_o), 64'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    check_all_zero("t6_rst");
    clear_inputs();
    nxt();
    nxt();
    rst_ni    = 1'b1;
    cpu_req_i = 3'b110;
    get_grant(who);
    chk("t6_after_rst", 64'(who), 64'd1);
    chk("t6_port", 64'(lookup_port_o), 64'd1);
    finish_txn();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
